ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
ID/EX pipeline register plus execute-side operand resolution. Sits directly upstream of the ALU and produces its `alu_op`, `operand_a` and `operand_b`. Captures decoded instruction fields each cycle and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. Detects load-use hazards and inserts bubbles, with upstream stall/flush control.

Parameters:
XLEN, 32, datapath width (ALU operand width)
REG_AW, 5, register address width
PC_W, 32, program counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  downstream freeze (e.g. D-cache miss); hold all state
flush  in  1  branch/jump mispredict; squash the instruction being captured
id_valid  in  1  decode slot holds a real instruction
id_alu_op  in  4  ALU op code (ADD=0,SUB=1,AND=2,OR=3,XOR=4,SRA=5,SRL=6,SLL=7,SLT=8,EQ=9)
id_rs1, id_rs2  in  REG_AW  source register indices
id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2
id_rs1_data, id_rs2_data  in  XLEN  register file read data
id_imm  in  XLEN  sign-extended immediate
id_use_imm  in  1  operand_b = imm
id_use_pc  in  1  operand_a = pc
id_pc  in  PC_W  instruction PC
id_rd  in  REG_AW  destination index
id_reg_write, id_mem_read, id_mem_write  in  1  control bits
exmem_rd  in  REG_AW;  exmem_reg_write  in  1;  exmem_result  in  XLEN  EX/MEM forward source
memwb_rd  in  REG_AW;  memwb_reg_write  in  1;  memwb_result  in  XLEN  MEM/WB forward source
hazard_stall  out  1  upstream must hold PC and IF/ID this cycle
ex_valid  out  1  stage holds a real instruction
alu_op  out  4  to ALU
operand_a, operand_b  out  XLEN  to ALU
ex_store_data  out  XLEN  forwarded rs2 for stores
ex_rd  out  REG_AW;  ex_reg_write, ex_mem_read, ex_mem_write, ex_pc  out  as captured

Behaviour:
- Update priority: rst > stall > flush > hazard bubble > normal capture.
- Reset: ex_valid=0, alu_op=0 (ADD), all control bits, rd, pc, imm and stored rs data = 0. operand_a = operand_b = ex_store_data = 0 and hazard_stall = 0 after reset.
- Normal capture: every id_* field is registered on the edge (1-cycle latency). ex_valid <= id_valid.
- stall=1: all fields hold, except stored rs1/rs2 data, which reload with their current forwarded values each cycle. A producer retiring from MEM/WB during a stall must not be lost. ex_valid holds.
- flush=1 (no stall): ex_valid, ex_reg_write, ex_mem_read and ex_mem_write <= 0. Other fields don't-care.
- Load-use: hazard_stall = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - When hazard_stall=1 and stall=0: insert a bubble (same clear as flush). Upstream re-presents the same ID instruction next cycle.
  - hazard_stall is combinational and masked to 0 when flush=1.
- Forwarding (combinational, after the register), per source:
  - Use exmem_result if exmem_reg_write & exmem_rd!=0 & exmem_rd==src.
  - Else use memwb_result under the same rule with memwb_* fields.
  - Else use the stored data.
  - EX/MEM wins when both match. x0 is never forwarded.
- operand_a = use_pc ? zero-extended pc : fwd_rs1. operand_b = use_imm ? imm : fwd_rs2. ex_store_data = fwd_rs2 regardless of use_imm.
- Outputs are valid even when ex_valid=0. Downstream qualifies all outputs with ex_valid.

Optional Feature:
EX_FORWARD_EN:
- Defined: forwarding exactly as above.
- Undefined: forwarding muxes are removed and operands come from stored data only.
  - hazard_stall extends to any valid RAW match against (ex_rd & ex_reg_write & ex_valid), (exmem_rd & exmem_reg_write) or (memwb_rd & memwb_reg_write), rd!=0.
  - A bubble is inserted each such cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU op localparams ADD..EQ (0..9)
  - REG_AW and XLEN defaults
  - the ALU op width constant (4)
- One sub-module, ex_fwd_mux: a 3-way priority forward select for one source index. It is instantiated twice (rs1, rs2) and is also used by the stall-refresh path.

Test Plan:
- Reset: assert rst for 2 cycles with id_valid=1 → ex_valid=0, alu_op=0, operand_a=operand_b=0, hazard_stall=0.
- EX/MEM forward: ID add rs1=5 captured, exmem_rd=5, exmem_reg_write=1, exmem_result=0x1234 → operand_a=0x1234. With memwb_rd=5 and result 0xBEEF also driven → still 0x1234.
- x0 guard: exmem_rd=0, exmem_reg_write=1, exmem_result=0xFFFF, id_rs2=0, stored 0 → operand_b=0.
- Load-use: ex holds lw rd=7, ID add rs1=7 valid → hazard_stall=1 and next cycle ex_valid=0. Cycle after, with exmem_rd=7 no longer load → add captured, operand_a = forwarded data.
- Stall refresh: ex holds rs1=3 with memwb_rd=3 result 0xA5A5. Assert stall 3 cycles while memwb changes to rd=9 → operand_a remains 0xA5A5.
- Flush/stall priority: flush=1 & stall=1 → state held, ex_valid unchanged. Next cycle flush=1 alone → ex_valid=0, ex_reg_write=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath defaults, ALU op codes and the forward-source select type.
package cpu_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int PC_W_DEF   = 32;
  localparam int ALU_OP_W   = 4;

  localparam logic [ALU_OP_W-1:0] ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] XOR = 4'd4;
  localparam logic [ALU_OP_W-1:0] SRA = 4'd5;
  localparam logic [ALU_OP_W-1:0] SRL = 4'd6;
  localparam logic [ALU_OP_W-1:0] SLL = 4'd7;
  localparam logic [ALU_OP_W-1:0] SLT = 4'd8;
  localparam logic [ALU_OP_W-1:0] EQ  = 4'd9;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_src_e;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode-side, forwarding-source and ALU-side signal bundle of the ID/EX operand stage.
interface ex_operand_stage_if
  import cpu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int PC_W   = PC_W_DEF
);
  logic                id_valid;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic [REG_AW-1:0]   id_rs1;
  logic [REG_AW-1:0]   id_rs2;
  logic                id_uses_rs1;
  logic                id_uses_rs2;
  logic [XLEN-1:0]     id_rs1_data;
  logic [XLEN-1:0]     id_rs2_data;
  logic [XLEN-1:0]     id_imm;
  logic                id_use_imm;
  logic                id_use_pc;
  logic [PC_W-1:0]     id_pc;
  logic [REG_AW-1:0]   id_rd;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                id_mem_write;

  logic [REG_AW-1:0]   exmem_rd;
  logic                exmem_reg_write;
  logic [XLEN-1:0]     exmem_result;
  logic [REG_AW-1:0]   memwb_rd;
  logic                memwb_reg_write;
  logic [XLEN-1:0]     memwb_result;

  logic                hazard_stall;
  logic                ex_valid;
  logic [ALU_OP_W-1:0] alu_op;
  logic [XLEN-1:0]     operand_a;
  logic [XLEN-1:0]     operand_b;
  logic [XLEN-1:0]     ex_store_data;
  logic [REG_AW-1:0]   ex_rd;
  logic                ex_reg_write;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic [PC_W-1:0]     ex_pc;

  modport master (
    output id_valid, id_alu_op, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_use_imm, id_use_pc, id_pc,
           id_rd, id_reg_write, id_mem_read, id_mem_write,
           exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_result,
    input  hazard_stall, ex_valid, alu_op, operand_a, operand_b, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_pc
  );

  modport slave (
    input  id_valid, id_alu_op, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_use_imm, id_use_pc, id_pc,
           id_rd, id_reg_write, id_mem_read, id_mem_write,
           exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_result,
    output hazard_stall, ex_valid, alu_op, operand_a, operand_b, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_pc
  );
endinterface

// File: rtl/ex_fwd_mux.sv
// Priority forward select for one source register: EX/MEM, then MEM/WB, then stored data; x0 never forwards.
module ex_fwd_mux
  import cpu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [XLEN-1:0]   stored_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_we_i,
  input  logic [XLEN-1:0]   exmem_result_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic              memwb_we_i,
  input  logic [XLEN-1:0]   memwb_result_i,
  output logic [XLEN-1:0]   data_o
);
  fwd_src_e sel;

  // Later assignment wins, so the younger EX/MEM producer overrides MEM/WB.
  always_comb begin
    sel = FWD_NONE;
    if (memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i)) sel = FWD_MEMWB;
    if (exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i)) sel = FWD_EXMEM;
  end

  always_comb begin
    data_o = stored_i;
    unique case (sel)
      FWD_EXMEM: data_o = exmem_result_i;
      FWD_MEMWB: data_o = memwb_result_i;
      default:   data_o = stored_i;
    endcase
  end
endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with operand forwarding and load-use bubble insertion.
// Build option EX_FORWARD_EN: defined = forward from EX/MEM and MEM/WB; undefined = stall on every RAW.
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  ex_operand_stage_if.slave  bus
);
  logic                valid_q,     valid_d;
  logic [ALU_OP_W-1:0] alu_op_q,    alu_op_d;
  logic [REG_AW-1:0]   rs1_q,       rs1_d;
  logic [REG_AW-1:0]   rs2_q,       rs2_d;
  logic [XLEN-1:0]     rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0]     rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0]     imm_q,       imm_d;
  logic                use_imm_q,   use_imm_d;
  logic                use_pc_q,    use_pc_d;
  logic [PC_W-1:0]     pc_q,        pc_d;
  logic [REG_AW-1:0]   rd_q,        rd_d;
  logic                reg_write_q, reg_write_d;
  logic                mem_read_q,  mem_read_d;
  logic                mem_write_q, mem_write_d;

  logic [XLEN-1:0]     fwd_rs1;
  logic [XLEN-1:0]     fwd_rs2;
  logic                hz_raw;
  logic                hz_stall;

  // True when the instruction in decode reads register rd and that producer is live.
  function automatic logic raw_hit(input logic [REG_AW-1:0] rd, input logic live,
                                   input logic id_v,
                                   input logic u1, input logic [REG_AW-1:0] s1,
                                   input logic u2, input logic [REG_AW-1:0] s2);
    return id_v && live && (rd != '0) && ((u1 && (s1 == rd)) || (u2 && (s2 == rd)));
  endfunction

  logic load_use;
  assign load_use = raw_hit(rd_q, valid_q & mem_read_q, bus.id_valid,
                            bus.id_uses_rs1, bus.id_rs1, bus.id_uses_rs2, bus.id_rs2);

`ifdef EX_FORWARD_EN
  ex_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .src_i          (rs1_q),
    .stored_i       (rs1_data_q),
    .exmem_rd_i     (bus.exmem_rd),
    .exmem_we_i     (bus.exmem_reg_write),
    .exmem_result_i (bus.exmem_result),
    .memwb_rd_i     (bus.memwb_rd),
    .memwb_we_i     (bus.memwb_reg_write),
    .memwb_result_i (bus.memwb_result),
    .data_o         (fwd_rs1)
  );

  ex_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .src_i          (rs2_q),
    .stored_i       (rs2_data_q),
    .exmem_rd_i     (bus.exmem_rd),
    .exmem_we_i     (bus.exmem_reg_write),
    .exmem_result_i (bus.exmem_result),
    .memwb_rd_i     (bus.memwb_rd),
    .memwb_we_i     (bus.memwb_reg_write),
    .memwb_result_i (bus.memwb_result),
    .data_o         (fwd_rs2)
  );

  assign hz_raw = load_use;
`else
  // Without bypass paths every in-flight producer of a decode source must drain first.
  assign fwd_rs1 = rs1_data_q;
  assign fwd_rs2 = rs2_data_q;

  logic unused_fwd_src;
  assign unused_fwd_src = ^{bus.exmem_result, bus.memwb_result, rs1_q, rs2_q};

  assign hz_raw = load_use
      | raw_hit(rd_q, valid_q & reg_write_q, bus.id_valid,
                bus.id_uses_rs1, bus.id_rs1, bus.id_uses_rs2, bus.id_rs2)
      | raw_hit(bus.exmem_rd, bus.exmem_reg_write, bus.id_valid,
                bus.id_uses_rs1, bus.id_rs1, bus.id_uses_rs2, bus.id_rs2)
      | raw_hit(bus.memwb_rd, bus.memwb_reg_write, bus.id_valid,
                bus.id_uses_rs1, bus.id_rs1, bus.id_uses_rs2, bus.id_rs2);
`endif

  assign hz_stall = hz_raw & ~flush;

  always_comb begin
    valid_d     = valid_q;
    alu_op_d    = alu_op_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    use_pc_d    = use_pc_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (stall) begin
      // Refresh held operands so a producer retiring during the freeze is not lost.
      rs1_data_d = fwd_rs1;
      rs2_data_d = fwd_rs2;
    end else begin
      valid_d     = bus.id_valid;
      alu_op_d    = bus.id_alu_op;
      rs1_d       = bus.id_rs1;
      rs2_d       = bus.id_rs2;
      rs1_data_d  = bus.id_rs1_data;
      rs2_data_d  = bus.id_rs2_data;
      imm_d       = bus.id_imm;
      use_imm_d   = bus.id_use_imm;
      use_pc_d    = bus.id_use_pc;
      pc_d        = bus.id_pc;
      rd_d        = bus.id_rd;
      reg_write_d = bus.id_reg_write;
      mem_read_d  = bus.id_mem_read;
      mem_write_d = bus.id_mem_write;
      if (flush || hz_stall) begin
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      alu_op_q    <= ADD;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      use_pc_q    <= 1'b0;
      pc_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      alu_op_q    <= alu_op_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      use_pc_q    <= use_pc_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign bus.hazard_stall  = hz_stall;
  assign bus.ex_valid      = valid_q;
  assign bus.alu_op        = alu_op_q;
  assign bus.operand_a     = use_pc_q ? XLEN'(pc_q) : fwd_rs1;
  assign bus.operand_b     = use_imm_q ? imm_q : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;
  assign bus.ex_pc         = pc_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed hazard/forwarding steps, then random traffic against a reference model.
module tb_ex_operand_stage;
  import cpu_pkg::*;

  localparam int XLEN = 32, REG_AW = 5, PC_W = 32;
`ifdef EX_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, stall, flush;
  always #5 clk = ~clk;

  ex_operand_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW), .PC_W(PC_W)) bus ();

  ex_operand_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .PC_W(PC_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Architectural contents of the EX slot as the rules define them.
  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic        ui, up, rw, mr, mw;
  } ex_t;
  ex_t m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] stored);
    if (FWD_ON && bus.exmem_reg_write && bus.exmem_rd != 0 && bus.exmem_rd == src) return bus.exmem_result;
    if (FWD_ON && bus.memwb_reg_write && bus.memwb_rd != 0 && bus.memwb_rd == src) return bus.memwb_result;
    return stored;
  endfunction

  function automatic logic reads(input logic [4:0] rd, input logic live);
    return bus.id_valid && live && rd != 0 &&
           ((bus.id_uses_rs1 && bus.id_rs1 == rd) || (bus.id_uses_rs2 && bus.id_rs2 == rd));
  endfunction

  function automatic logic ref_hazard();
    logic h;
    h = reads(m.rd, m.valid && m.mr);
    if (!FWD_ON)
      h = h | reads(m.rd, m.valid && m.rw) | reads(bus.exmem_rd, bus.exmem_reg_write)
            | reads(bus.memwb_rd, bus.memwb_reg_write);
    return h && !flush;
  endfunction

  // Check the current cycle against the model, advance the model, move to the next falling edge.
  task automatic tick();
    logic [31:0] f1, f2;
    logic hz;
    #1;
    f1 = ref_fwd(m.rs1, m.d1);
    f2 = ref_fwd(m.rs2, m.d2);
    hz = ref_hazard();
    chk("hazard_stall", bus.hazard_stall, hz);
    chk("ex_valid", bus.ex_valid, m.valid);
    chk("ex_reg_write", bus.ex_reg_write, m.rw);
    chk("ex_mem_read", bus.ex_mem_read, m.mr);
    chk("ex_mem_write", bus.ex_mem_write, m.mw);
    if (m.valid) begin
      chk("alu_op", bus.alu_op, m.op);
      chk("operand_a", bus.operand_a, m.up ? m.pc : f1);
      chk("operand_b", bus.operand_b, m.ui ? m.imm : f2);
      chk("ex_store_data", bus.ex_store_data, f2);
      chk("ex_rd", bus.ex_rd, m.rd);
      chk("ex_pc", bus.ex_pc, m.pc);
    end
    if (rst) begin
      m = '{default: '0};
    end else if (stall) begin
      m.d1 = f1;
      m.d2 = f2;
    end else begin
      m.valid = bus.id_valid;   m.op = bus.id_alu_op;
      m.rs1 = bus.id_rs1;       m.rs2 = bus.id_rs2;      m.rd = bus.id_rd;
      m.d1 = bus.id_rs1_data;   m.d2 = bus.id_rs2_data;
      m.imm = bus.id_imm;       m.pc = bus.id_pc;
      m.ui = bus.id_use_imm;    m.up = bus.id_use_pc;
      m.rw = bus.id_reg_write;  m.mr = bus.id_mem_read;  m.mw = bus.id_mem_write;
      if (flush || hz) begin
        m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_fwd();
    bus.exmem_rd = '0; bus.exmem_reg_write = 1'b0; bus.exmem_result = '0;
    bus.memwb_rd = '0; bus.memwb_reg_write = 1'b0; bus.memwb_result = '0;
  endtask

  task automatic id_set(input logic v, input logic [3:0] op,
                        input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic ui,
                        input logic [4:0] rd, input logic rw, input logic mr);
    bus.id_valid = v;       bus.id_alu_op = op;
    bus.id_rs1 = rs1;       bus.id_rs1_data = d1;   bus.id_uses_rs1 = 1'b1;
    bus.id_rs2 = rs2;       bus.id_rs2_data = d2;   bus.id_uses_rs2 = 1'b1;
    bus.id_imm = imm;       bus.id_use_imm = ui;    bus.id_use_pc = 1'b0;
    bus.id_pc = 32'h0000_1000;
    bus.id_rd = rd;         bus.id_reg_write = rw;  bus.id_mem_read = mr;
    bus.id_mem_write = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.id_valid     = ($urandom_range(0, 3) != 0);
    bus.id_alu_op    = 4'($urandom_range(0, 9));
    bus.id_rs1       = 5'($urandom_range(0, 7));
    bus.id_rs2       = 5'($urandom_range(0, 7));
    bus.id_uses_rs1  = 1'($urandom);
    bus.id_uses_rs2  = 1'($urandom);
    bus.id_rs1_data  = $urandom;
    bus.id_rs2_data  = $urandom;
    bus.id_imm       = $urandom;
    bus.id_use_imm   = 1'($urandom);
    bus.id_use_pc    = ($urandom_range(0, 3) == 0);
    bus.id_pc        = $urandom;
    bus.id_rd        = 5'($urandom_range(0, 7));
    bus.id_reg_write = 1'($urandom);
    bus.id_mem_read  = ($urandom_range(0, 2) == 0);
    bus.id_mem_write = ($urandom_range(0, 4) == 0);
    bus.exmem_rd        = 5'($urandom_range(0, 7));
    bus.exmem_reg_write = 1'($urandom);
    bus.exmem_result    = $urandom;
    bus.memwb_rd        = 5'($urandom_range(0, 7));
    bus.memwb_reg_write = 1'($urandom);
    bus.memwb_result    = $urandom;
    stall = ($urandom_range(0, 7) == 0);
    flush = ($urandom_range(0, 9) == 0);
    rst   = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    m = '{default: '0};
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    clear_fwd();
    id_set(1'b1, SUB, 5'd4, 32'hCAFE_0001, 5'd6, 32'hCAFE_0002, 32'h10, 1'b1, 5'd4, 1'b1, 1'b1);
    @(negedge clk);

    // Reset held two cycles with a valid instruction presented.
    tick();
    tick();
    chk("rst_ex_valid", bus.ex_valid, 1'b0);
    chk("rst_alu_op", bus.alu_op, ADD);
    chk("rst_operand_a", bus.operand_a, 32'h0);
    chk("rst_operand_b", bus.operand_b, 32'h0);
    chk("rst_store_data", bus.ex_store_data, 32'h0);
    chk("rst_hazard", bus.hazard_stall, 1'b0);
    rst = 1'b0;

    // EX/MEM forward and its priority over MEM/WB.
    id_set(1'b1, ADD, 5'd5, 32'h1111, 5'd6, 32'h2222, 32'h0, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    bus.id_valid = 1'b0;
    bus.exmem_rd = 5'd5; bus.exmem_reg_write = 1'b1; bus.exmem_result = 32'h1234;
    #1 chk("fwd_exmem", bus.operand_a, FWD_ON ? 32'h1234 : 32'h1111);
    bus.memwb_rd = 5'd5; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'hBEEF;
    #1 chk("fwd_exmem_over_memwb", bus.operand_a, FWD_ON ? 32'h1234 : 32'h1111);
    tick();

    // x0 is never forwarded.
    clear_fwd();
    id_set(1'b1, OR, 5'd1, 32'h55, 5'd0, 32'h0, 32'h0, 1'b0, 5'd2, 1'b1, 1'b0);
    tick();
    bus.id_valid = 1'b0;
    bus.exmem_rd = 5'd0; bus.exmem_reg_write = 1'b1; bus.exmem_result = 32'hFFFF;
    #1 chk("x0_guard_operand_b", bus.operand_b, 32'h0);
    chk("x0_guard_store", bus.ex_store_data, 32'h0);
    tick();

    // Load-use: lw x7 in EX, add reading x7 in decode.
    clear_fwd();
    id_set(1'b1, ADD, 5'd2, 32'h40, 5'd0, 32'h0, 32'h8, 1'b1, 5'd7, 1'b1, 1'b1);
    tick();
    id_set(1'b1, ADD, 5'd7, 32'hDEAD, 5'd3, 32'h3, 32'h0, 1'b0, 5'd8, 1'b1, 1'b0);
    #1 chk("loaduse_stall", bus.hazard_stall, 1'b1);
    tick();
    chk("loaduse_bubble", bus.ex_valid, 1'b0);
    bus.exmem_rd = 5'd7; bus.exmem_reg_write = 1'b1; bus.exmem_result = 32'h7777;
    #1 chk("loaduse_release", bus.hazard_stall, FWD_ON ? 1'b0 : 1'b1);
    tick();
    clear_fwd();
    bus.memwb_rd = 5'd7; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'h7777;
    #1 chk("loaduse_captured", bus.ex_valid, FWD_ON ? 1'b1 : 1'b0);
`ifdef EX_FORWARD_EN
    chk("loaduse_operand_a", bus.operand_a, 32'h7777);
`else
    chk("raw_memwb_stall", bus.hazard_stall, 1'b1);
`endif
    bus.id_valid = 1'b0;
    clear_fwd();
    tick();

    // Stall refresh: MEM/WB producer retires during a three-cycle freeze.
    id_set(1'b1, XOR, 5'd3, 32'h3333, 5'd4, 32'h4444, 32'h0, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    bus.id_valid = 1'b0;
    stall = 1'b1;
    bus.memwb_rd = 5'd3; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'hA5A5;
    #1 chk("stall_fwd", bus.operand_a, FWD_ON ? 32'hA5A5 : 32'h3333);
    tick();
    bus.memwb_rd = 5'd9; bus.memwb_result = 32'h9999;
    #1 chk("stall_refresh_1", bus.operand_a, FWD_ON ? 32'hA5A5 : 32'h3333);
    tick();
    #1 chk("stall_refresh_2", bus.operand_a, FWD_ON ? 32'hA5A5 : 32'h3333);
    chk("stall_valid_held", bus.ex_valid, 1'b1);
    tick();

    // Stall outranks flush; flush alone squashes.
    clear_fwd();
    bus.id_valid = 1'b1; bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    flush = 1'b1;
    tick();
    chk("flush_stall_valid", bus.ex_valid, 1'b1);
    chk("flush_stall_reg_write", bus.ex_reg_write, 1'b1);
    stall = 1'b0;
    tick();
    chk("flush_valid", bus.ex_valid, 1'b0);
    chk("flush_reg_write", bus.ex_reg_write, 1'b0);
    flush = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rand_inputs();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
